// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: stall/flush/forward control plus imem wait tracking.
// Optional HAZARD_PERF_CNT_EN builds saturating StallF/FlushE cycle counters.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int IMEM_TIMEOUT = 255,
    parameter int TO_W         = 8,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              imem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              imem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        IWAIT   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(IMEM_TIMEOUT);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            imem_err_q, imem_err_d;
    logic            lw_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            imem_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            imem_err_q <= imem_err_d;
        end
    end

    // A taken branch while the fetch is still outstanding makes that response wrong-path.
    always_comb begin
        state_d = state_q;
        if (PCSrcE) begin
            state_d = imem_ready ? RUN : DISCARD;
        end else begin
            unique case (state_q)
                RUN:     state_d = imem_ready ? RUN : IWAIT;
                IWAIT:   state_d = imem_ready ? RUN : IWAIT;
                DISCARD: state_d = imem_ready ? RUN : DISCARD;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d == RUN) begin
            wait_cnt_d = '0;
        end else if ((state_q != RUN) && !imem_ready && (wait_cnt_q != TIMEOUT_V)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        imem_err_d = imem_err_q | (wait_cnt_d == TIMEOUT_V);
    end

    assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign imem_err = imem_err_q;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (reset || PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (!imem_ready || (state_q == DISCARD)) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end
    end

    // M-stage result is newer than W-stage, so it wins when both match.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (FlushE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
